// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped I/O controller: register offsets
// within the 4-word window and the default window base.
package io_pkg;

  localparam logic [31:0] DEF_BASE_ADDR = 32'd4096;

  localparam logic [1:0] OFF_SW       = 2'd0;
  localparam logic [1:0] OFF_LED      = 2'd1;
  localparam logic [1:0] OFF_BTN_EVT  = 2'd2;
  localparam logic [1:0] OFF_IRQ_MASK = 2'd3;

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser followed by a shared-counter debouncer: the whole
// vector must hold steady for DEBOUNCE_CYCLES cycles before stable follows.
module io_debounce #(
  parameter int unsigned W               = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     meta_q;
  logic [W-1:0]     sync_q;
  logic [W-1:0]     cand_q;
  logic [W-1:0]     stable_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      // Any difference from the candidate restarts the settle window.
      if (sync_q != cand_q) begin
        cand_q <= sync_q;
        cnt_q  <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= cand_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped switch/button/LED controller with a 4-word register window.
// Optional macro IO_IRQ_EN adds the interrupt mask register and the irq output.
module mmio_io_ctrl
  import io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = DEF_BASE_ADDR,
  parameter int unsigned SW_W            = 16,
  parameter int unsigned LED_W           = 16,
  parameter int unsigned BTN_W           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       address_dmem,
  input  logic              wren,
  input  logic [31:0]       data,
  output logic              io_sel,
  output logic [31:0]       io_q,
  input  logic [SW_W-1:0]   SW,
  input  logic [BTN_W-1:0]  BTN,
  output logic [LED_W-1:0]  LED,
  output logic              irq
);

  logic [1:0]       offset;
  logic [SW_W-1:0]  sw_stable;
  logic [BTN_W-1:0] btn_stable;
  logic [BTN_W-1:0] btn_prev_q;
  logic [BTN_W-1:0] btn_rise;
  logic [BTN_W-1:0] btn_clr;
  logic [BTN_W-1:0] btn_evt_q;
  logic [BTN_W-1:0] btn_evt_d;
  logic [LED_W-1:0] led_q;
  logic [31:0]      rdata;
  logic             wr_led;
  logic             wr_evt;
  logic             unused_bits;

  assign io_sel = (address_dmem >= BASE_ADDR) && (address_dmem <= BASE_ADDR + 32'd3);
  assign offset = address_dmem[1:0] - BASE_ADDR[1:0];

  assign wr_led = wren && io_sel && (offset == OFF_LED);
  assign wr_evt = wren && io_sel && (offset == OFF_BTN_EVT);

  io_debounce #(
    .W               (SW_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (SW),
    .stable  (sw_stable)
  );

  io_debounce #(
    .W               (BTN_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (BTN),
    .stable  (btn_stable)
  );

  // A new press is OR-ed in after the clear so it survives a coincident W1C.
  assign btn_rise  = btn_stable & ~btn_prev_q;
  assign btn_clr   = wr_evt ? data[BTN_W-1:0] : '0;
  assign btn_evt_d = (btn_evt_q & ~btn_clr) | btn_rise;

`ifdef IO_IRQ_EN
  logic [BTN_W-1:0] irq_mask_q;
  logic             wr_mask;

  assign wr_mask = wren && io_sel && (offset == OFF_IRQ_MASK);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      irq        <= 1'b0;
    end else begin
      if (wr_mask) irq_mask_q <= data[BTN_W-1:0];
      irq <= |(btn_evt_q & irq_mask_q);
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (io_sel) begin
      unique case (offset)
        OFF_SW:      rdata[SW_W-1:0]  = sw_stable;
        OFF_LED:     rdata[LED_W-1:0] = led_q;
        OFF_BTN_EVT: rdata[BTN_W-1:0] = btn_evt_q;
        OFF_IRQ_MASK: begin
`ifdef IO_IRQ_EN
          rdata[BTN_W-1:0] = irq_mask_q;
`else
          rdata = '0;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      led_q      <= '0;
      btn_evt_q  <= '0;
      btn_prev_q <= '0;
      io_q       <= '0;
    end else begin
      io_q       <= rdata;
      btn_prev_q <= btn_stable;
      btn_evt_q  <= btn_evt_d;
      if (wr_led) led_q <= data[LED_W-1:0];
    end
  end

  assign LED = led_q;

  // Only the low bits of the write data are architecturally meaningful.
  assign unused_bits = ^data;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Scoreboard-driven bench for mmio_io_ctrl with a short debounce window.
// Define IO_IRQ_EN for both bench and RTL to exercise the interrupt path.
module tb_mmio_io_ctrl;

  localparam int unsigned DB = 4;
  localparam logic [31:0] BASE = 32'd4096;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] address_dmem;
  logic        wren;
  logic [31:0] data;
  logic        io_sel;
  logic [31:0] io_q;
  logic [15:0] SW;
  logic [3:0]  BTN;
  logic [15:0] LED;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  logic [31:0] exp_q[$];

  mmio_io_ctrl #(
    .BASE_ADDR       (BASE),
    .SW_W            (16),
    .LED_W           (16),
    .BTN_W           (4),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address_dmem (address_dmem),
    .wren         (wren),
    .data         (data),
    .io_sel       (io_sel),
    .io_q         (io_q),
    .SW           (SW),
    .BTN          (BTN),
    .LED          (LED),
    .irq          (irq)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    SW = '0;
    BTN = '0;
    wren = 1'b0;
    data = '0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [6];
    logic        sels [6];
    address_dmem = BASE + 32'd1;
    apply_reset();
    checks++;
    if (LED !== 16'h0) begin
      errors++;
      $display("FAIL reset_led: got %h expected %h", LED, 16'h0);
    end
    checks++;
    if (io_q !== 32'h0) begin
      errors++;
      $display("FAIL reset_io_q: got %h expected %h", io_q, 32'h0);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    addrs = '{32'd4095, 32'd4096, 32'd4099, 32'd4100, 32'd0, 32'hFFFF_FFFF};
    sels  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      address_dmem = addrs[i];
      #1;
      checks++;
      if (io_sel !== sels[i]) begin
        errors++;
        $display("FAIL decode_%0d: got %b expected %b", addrs[i], io_sel, sels[i]);
      end
    end
  endtask

  task automatic test_sw_debounce();
    logic [31:0] got;
    address_dmem = BASE;
    apply_reset();
    SW = 16'hA5A5;
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back((k >= DB + 4) ? 32'h0000_A5A5 : 32'h0);
      tick();
      got = exp_q.pop_front();
      checks++;
      if (io_q !== got) begin
        errors++;
        $display("FAIL sw_settle_k%0d: got %h expected %h", k, io_q, got);
      end
    end
  endtask

  task automatic test_sw_glitch();
    logic [31:0] got;
    address_dmem = BASE;
    apply_reset();
    for (int k = 1; k <= 32; k++) begin
      if (k - 1 < 20 && ((k - 1) % 2) == 0) SW = (((k - 1) / 2) % 2 == 0) ? 16'h1 : 16'h0;
      if (k - 1 == 20) SW = 16'h1;
      exp_q.push_back((k >= 20 + DB + 4) ? 32'h1 : 32'h0);
      tick();
      got = exp_q.pop_front();
      checks++;
      if (io_q !== got) begin
        errors++;
        $display("FAIL sw_glitch_k%0d: got %h expected %h", k, io_q, got);
      end
    end
  endtask

  task automatic test_led();
    logic [31:0] got;
    apply_reset();
    address_dmem = BASE + 32'd1;
    wren = 1'b1;
    data = 32'hFFFF_1234;
    exp_q.push_back(32'h0);
    tick();
    wren = 1'b0;
    got = exp_q.pop_front();
    checks++;
    if (io_q !== got) begin
      errors++;
      $display("FAIL led_prewrite_read: got %h expected %h", io_q, got);
    end
    checks++;
    if (LED !== 16'h1234) begin
      errors++;
      $display("FAIL led_write: got %h expected %h", LED, 16'h1234);
    end
    exp_q.push_back(32'h0000_1234);
    tick();
    got = exp_q.pop_front();
    checks++;
    if (io_q !== got) begin
      errors++;
      $display("FAIL led_readback: got %h expected %h", io_q, got);
    end
    address_dmem = BASE;
    wren = 1'b1;
    data = 32'h0000_0000;
    exp_q.push_back(32'h0);
    tick();
    wren = 1'b0;
    got = exp_q.pop_front();
    checks++;
    if (io_q !== got || LED !== 16'h1234) begin
      errors++;
      $display("FAIL sw_write_ignored: got io_q=%h LED=%h expected io_q=%h LED=1234",
               io_q, LED, got);
    end
    address_dmem = BASE + 32'd4;
    wren = 1'b1;
    data = 32'h0000_BEEF;
    tick();
    wren = 1'b0;
    checks++;
    if (LED !== 16'h1234 || io_q !== 32'h0) begin
      errors++;
      $display("FAIL out_of_window_write: got LED=%h io_q=%h expected LED=1234 io_q=0",
               LED, io_q);
    end
    address_dmem = BASE + 32'd1;
    wren = 1'b1;
    data = 32'h0000_5678;
    tick();
    wren = 1'b0;
    exp_q.push_back(32'h0000_5678);
    tick();
    got = exp_q.pop_front();
    checks++;
    if (io_q !== got || LED !== 16'h5678) begin
      errors++;
      $display("FAIL led_second: got io_q=%h LED=%h expected %h", io_q, LED, got);
    end
  endtask

  task automatic test_btn_evt();
    logic [31:0] got;
    logic        found;
    apply_reset();
    address_dmem = BASE + 32'd2;
    BTN = 4'b0100;
    found = 1'b0;
    lat = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      lat++;
      if (io_q === 32'h4) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL btn_evt_set: got %h expected %h (timeout)", io_q, 32'h4);
    end
    wren = 1'b1;
    data = 32'h4;
    exp_q.push_back(32'h4);
    tick();
    wren = 1'b0;
    got = exp_q.pop_front();
    checks++;
    if (io_q !== got) begin
      errors++;
      $display("FAIL btn_w1c_preread: got %h expected %h", io_q, got);
    end
    exp_q.push_back(32'h0);
    tick();
    got = exp_q.pop_front();
    checks++;
    if (io_q !== got) begin
      errors++;
      $display("FAIL btn_w1c: got %h expected %h", io_q, got);
    end
    BTN = 4'b0000;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (io_q !== 32'h0) begin
      errors++;
      $display("FAIL btn_release_no_evt: got %h expected %h", io_q, 32'h0);
    end
    // Replay the press so the W1C lands on the very edge that sets the event.
    BTN = 4'b0100;
    for (int i = 0; i < lat - 2; i++) tick();
    wren = 1'b1;
    data = 32'h4;
    tick();
    wren = 1'b0;
    exp_q.push_back(32'h4);
    tick();
    got = exp_q.pop_front();
    checks++;
    if (io_q !== got) begin
      errors++;
      $display("FAIL btn_set_beats_w1c: got %h expected %h", io_q, got);
    end
  endtask

  task automatic test_irq();
    logic [31:0] got;
    logic        found;
    logic        prev_irq;
    apply_reset();
`ifdef IO_IRQ_EN
    address_dmem = BASE + 32'd3;
    wren = 1'b1;
    data = 32'h0000_0004;
    tick();
    wren = 1'b0;
    exp_q.push_back(32'h4);
    tick();
    got = exp_q.pop_front();
    checks++;
    if (io_q !== got) begin
      errors++;
      $display("FAIL irq_mask_read: got %h expected %h", io_q, got);
    end
    address_dmem = BASE + 32'd2;
    BTN = 4'b0100;
    found = 1'b0;
    prev_irq = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      prev_irq = irq;
      tick();
      if (io_q === 32'h4) found = 1'b1;
    end
    checks++;
    if (!found || irq !== 1'b1 || prev_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_assert: got irq=%b prev=%b found=%b expected irq=1 prev=0 found=1",
               irq, prev_irq, found);
    end
    address_dmem = BASE + 32'd3;
    wren = 1'b1;
    data = 32'h0;
    tick();
    wren = 1'b0;
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_masked_off: got %b expected 0", irq);
    end
`else
    address_dmem = BASE + 32'd3;
    wren = 1'b1;
    data = 32'h0000_000F;
    tick();
    wren = 1'b0;
    exp_q.push_back(32'h0);
    tick();
    got = exp_q.pop_front();
    checks++;
    if (io_q !== got) begin
      errors++;
      $display("FAIL mask_absent_read: got %h expected %h", io_q, got);
    end
    BTN = 4'b1111;
    found = 1'b0;
    prev_irq = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      prev_irq = prev_irq | irq;
    end
    checks++;
    if (prev_irq !== 1'b0 || found !== 1'b0) begin
      errors++;
      $display("FAIL irq_tied_low: got %b expected 0", prev_irq);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    logic        found;
    apply_reset();
    address_dmem = BASE + 32'd2;
    BTN = 4'b1111;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (io_q === 32'hF) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL btn_all_evt: got %h expected %h (timeout)", io_q, 32'hF);
    end
    address_dmem = BASE + 32'd1;
    wren = 1'b1;
    data = 32'h0000_1234;
    tick();
    wren = 1'b0;
    SW = 16'hA5A5;
    tick();
    tick();
    tick();
    address_dmem = BASE + 32'd2;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (LED !== 16'h0 || io_q !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got LED=%h io_q=%h irq=%b expected all 0",
               LED, io_q, irq);
    end
    // The switch change must restart from scratch after reset.
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) exp_q.push_back(32'h0);
      else exp_q.push_back((k >= DB + 4) ? 32'h0000_A5A5 : 32'h0);
      tick();
      address_dmem = BASE;
      got = exp_q.pop_front();
      checks++;
      if (io_q !== got) begin
        errors++;
        $display("FAIL post_reset_k%0d: got %h expected %h", k, io_q, got);
      end
    end
    address_dmem = BASE + 32'd4;
    #1;
    exp_q.push_back(32'h0);
    checks++;
    if (io_sel !== 1'b0) begin
      errors++;
      $display("FAIL sel_4100: got %b expected 0", io_sel);
    end
    tick();
    got = exp_q.pop_front();
    checks++;
    if (io_q !== got) begin
      errors++;
      $display("FAIL read_4100: got %h expected %h", io_q, got);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    address_dmem = '0;
    wren = 1'b0;
    data = '0;
    SW = '0;
    BTN = '0;
    tick();
    test_reset();
    test_sw_debounce();
    test_sw_glitch();
    test_led();
    test_btn_evt();
    test_irq();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
Memory-mapped I/O controller between the processor data-memory port and the board switches, buttons and LEDs. Decodes a 4-word I/O window in the data address space and returns registered read data that the top level muxes onto q_dmem in place of RAM output. Synchronises and debounces switches and buttons, latches button press events, and drives the LED register.

Parameters:
BASE_ADDR, 32'd4096, word address of I/O window (offset 0 SW, 1 LED, 2 BTN_EVT, 3 IRQ_MASK)
SW_W, 16, switch count
LED_W, 16, LED count
BTN_W, 4, button count (BTNC/BTNL/BTNR/BTND; BTNU is reset)
DEBOUNCE_CYCLES, 250000, stable cycles required before a debounced input updates; minimum 1
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width

Ports:
clock  in  1  system clock (PLL output)
reset_n  in  1  synchronous active-low reset
address_dmem  in  32  processor data address
wren  in  1  processor data write enable
data  in  32  processor write data
io_sel  out  1  combinational: address_dmem within BASE_ADDR..BASE_ADDR+3
io_q  out  32  registered read data
SW  in  SW_W  raw switches (asynchronous)
BTN  in  BTN_W  raw buttons (asynchronous)
LED  out  LED_W  LED register
irq  out  1  event interrupt (IO_IRQ_EN only, else constant 0)

Behaviour:
- Reset (reset_n=0 at posedge): LED, io_q, sync flops, candidates, stable values, counters, event register, mask all 0. Reset mid-debounce discards progress.
- Decode: io_sel = (address_dmem >= BASE_ADDR) && (address_dmem <= BASE_ADDR+3); full 32-bit compare.
- Read: at each posedge io_q <= register at the sampled address: off0 {zero, sw_stable}; off1 {zero, LED}; off2 {zero, btn_evt}; off3 {zero, irq_mask}; io_sel=0 -> 0. Latency 1 cycle, matching RAM. Reads have no side effects.
- Write (wren=1, io_sel=1, at posedge): off1 LED <= data[LED_W-1:0]; off2 btn_evt <= btn_evt & ~data[BTN_W-1:0] (write-1-to-clear); off3 irq_mask <= data[BTN_W-1:0]; off0 ignored. Read in the same cycle as a write returns the pre-write value.
- Debounce (identical for SW and BTN, independent counters): 2-flop synchroniser -> sync. If sync != cand: cand <= sync, cnt <= 0. Else if cnt == DEBOUNCE_CYCLES-1: stable <= cand, cnt holds. Else cnt++. Raw change at edge 0 appears in stable at edge 3+DEBOUNCE_CYCLES if held; any glitch restarts the count. Whole vector shares one counter per instance.
- Events: btn_evt[i] set when btn_stable[i] goes 0->1. Sticky until cleared. Simultaneous set and W1C of same bit: set wins (bit stays 1).
- Out-of-window addresses: no state change, io_q 0.

Optional Feature:
IO_IRQ_EN: when defined, irq_mask register exists at offset 3 and irq is registered: irq <= |(btn_evt & irq_mask), one cycle after the event/mask update. When undefined, offset 3 reads 0, writes ignored, irq tied 0, no mask flops.

Decomposition:
- Package io_pkg: offset constants OFF_SW=0, OFF_LED=1, OFF_BTN_EVT=2, OFF_IRQ_MASK=3; default BASE_ADDR.
- Sub-module io_debounce (params W, DEBOUNCE_CYCLES; ports clock, reset_n, raw, stable): synchroniser plus counter, instantiated for SW and BTN.

Test Plan:
- DEBOUNCE_CYCLES=4; reset, SW=16'hA5A5 held from edge 0 -> read off0 returns 0 before edge 7, 32'h0000A5A5 after; io_q valid 1 cycle after address.
- SW toggles 0x0001/0x0000 every 2 cycles for 20 cycles then holds 0x0001 -> sw_stable stays 0 throughout toggling, becomes 0x0001 7 cycles after last change.
- Write 32'hFFFF1234 to 4097 -> LED=16'h1234 next cycle; read 4097 -> 32'h00001234; write to 4096 -> no change.
- BTN[2] pressed and held -> btn_evt=4'b0100; write 4'b0100 to 4098 -> 0; same-cycle new rising edge and W1C -> bit remains 1.
- IO_IRQ_EN: mask=4'b0100 then BTN[2] event -> irq=1 one cycle after btn_evt sets; mask=0 -> irq=0; without macro irq=0, read 4099 -> 0.
- reset_n low mid-debounce and with LED=0x1234, btn_evt=0xF -> all outputs 0 next cycle; read address 4100 -> io_sel=0, io_q=0.
